// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data RAM: CPU vs host/debug loader,
// round-robin with a bounded host lock, one RAM access per cycle, registered read return.
module mem_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int MAX_LOCK  = 16
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [DATA_BITS-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [DATA_BITS-1:0] cpu_rdata,

    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [DATA_BITS-1:0] host_wdata,
    input  logic                 host_lock,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_BITS-1:0] host_rdata,

    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_wdata,
    input  logic [DATA_BITS-1:0] ram_rdata,

    output logic                 locked
);

    localparam int CNT_BITS = 8;
    localparam logic [CNT_BITS-1:0] LOCK_LIMIT = CNT_BITS'(MAX_LOCK);

    typedef enum logic { RR, LOCKED } state_t;
    typedef enum logic { OWN_CPU, OWN_HOST } owner_t;

    typedef struct packed {
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } mem_req_t;

    state_t              state, state_nxt;
    owner_t              last_grant, last_grant_nxt;
    logic [CNT_BITS-1:0] lock_cnt, lock_cnt_nxt;

    mem_req_t cpu_rq, host_rq, win_rq;

    assign cpu_rq  = '{we: cpu_we,  addr: cpu_addr,  wdata: cpu_wdata};
    assign host_rq = '{we: host_we, addr: host_addr, wdata: host_wdata};

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RR;
            last_grant <= OWN_HOST;
            lock_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        lock_cnt_nxt   = lock_cnt;
        cpu_gnt        = 1'b0;
        host_gnt       = 1'b0;
        case (state)
            RR: begin
                if (cpu_req && (!host_req || last_grant == OWN_HOST))
                    cpu_gnt = 1'b1;
                else if (host_req)
                    host_gnt = 1'b1;

                if (cpu_gnt)
                    last_grant_nxt = OWN_CPU;
                if (host_gnt) begin
                    last_grant_nxt = OWN_HOST;
                    if (host_lock) begin
                        state_nxt    = LOCKED;
                        lock_cnt_nxt = CNT_BITS'(1);
                    end
                end
            end
            LOCKED: begin
                // CPU is held off; the count runs whether or not the host is using the slot.
                host_gnt     = host_req;
                lock_cnt_nxt = lock_cnt + CNT_BITS'(1);
                if (!host_lock || lock_cnt == LOCK_LIMIT) begin
                    state_nxt      = RR;
                    lock_cnt_nxt   = '0;
                    last_grant_nxt = OWN_HOST;
                end
            end
            default: state_nxt = RR;
        endcase
        if (reset) begin
            cpu_gnt  = 1'b0;
            host_gnt = 1'b0;
        end
    end

    // With no grant the mux parks on the CPU address and the write enable stays low.
    assign win_rq    = host_gnt ? host_rq : cpu_rq;
    assign ram_addr  = win_rq.addr;
    assign ram_wdata = win_rq.wdata;
    assign ram_we    = win_rq.we & (cpu_gnt | host_gnt);
    assign locked    = (state == LOCKED);

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
        end else begin
            cpu_rvalid  <= cpu_gnt & ~cpu_we;
            host_rvalid <= host_gnt & ~host_we;
            if (cpu_gnt && !cpu_we)
                cpu_rdata <= ram_rdata;
            if (host_gnt && !host_we)
                host_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM; MAX_LOCK reduced to 4.
module tb_mem_arbiter;

    logic       clock;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       ram_we, locked;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    logic       pre_we;
    logic [7:0] pre_addr, pre_wdata;
    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .MAX_LOCK(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .locked(locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pre_we) mem[pre_addr] <= pre_wdata;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1; pre_addr = a; pre_wdata = d;
        step();
        pre_we = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h44;
        host_req = 1; host_we = 1; host_addr = 8'h55; host_lock = 1;
        step();
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, host_gnt, ram_we} !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt got=%b want=000", {cpu_gnt, host_gnt, ram_we});
        end
        n_cmp++;
        if ({cpu_rvalid, host_rvalid, locked} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=000", {cpu_rvalid, host_rvalid, locked});
        end
        n_cmp++;
        if ({cpu_rdata, host_rdata} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_rdata got=%h want=0000", {cpu_rdata, host_rdata});
        end
        step();
        reset = 0; idle();
        cpu_addr = 8'h77; cpu_we = 1; host_addr = 8'h11;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, host_gnt, ram_we, ram_addr} !== {3'b000, 8'h77}) begin
            n_fail++; $display("FAIL idle_mux got=%b/%h want=000/77", {cpu_gnt, host_gnt, ram_we}, ram_addr);
        end
        step();
        idle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, host_gnt, ram_we, ram_addr} !== {3'b100, 8'h10}) begin
            n_fail++; $display("FAIL cpu_read_gnt got=%b/%h want=100/10", {cpu_gnt, host_gnt, ram_we}, ram_addr);
        end
        step();
        cpu_req = 0;
        n_cmp++;
        if ({cpu_rvalid, host_rvalid, cpu_rdata} !== {2'b10, 8'h5A}) begin
            n_fail++; $display("FAIL cpu_read_data got=%b/%h want=10/5a", {cpu_rvalid, host_rvalid}, cpu_rdata);
        end
        step();
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'h5A}) begin
            n_fail++; $display("FAIL cpu_read_hold got=%b/%h want=0/5a", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_addr;
        do_reset();
        cpu_req = 1; cpu_addr = 8'h01;
        host_req = 1; host_addr = 8'h02;
        for (int i = 0; i < 6; i++) begin
            exp_addr = (i % 2 == 0) ? 8'h01 : 8'h02;
            @(negedge clock);
            n_cmp++;
            if ({cpu_gnt, host_gnt, ram_addr} !== {(i % 2 == 0) ? 2'b10 : 2'b01, exp_addr}) begin
                n_fail++; $display("FAIL alternate_gnt cyc=%0d got=%b/%h want_addr=%h", i, {cpu_gnt, host_gnt}, ram_addr, exp_addr);
            end
            step();
            n_cmp++;
            if ({cpu_rvalid, host_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL alternate_rvalid cyc=%0d got=%b", i, {cpu_rvalid, host_rvalid});
            end
        end
        idle();
    endtask

    task automatic test_write_then_read();
        host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h33;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, host_gnt, ram_we, ram_addr, ram_wdata} !== {3'b011, 8'h20, 8'h33}) begin
            n_fail++; $display("FAIL host_write got=%b/%h/%h want=011/20/33", {cpu_gnt, host_gnt, ram_we}, ram_addr, ram_wdata);
        end
        step();
        idle();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
        n_cmp++;
        if (host_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL write_no_rvalid got=%b want=0", host_rvalid);
        end
        @(negedge clock);
        n_cmp++;
        if (cpu_gnt !== 1'b1) begin
            n_fail++; $display("FAIL raw_gnt got=%b want=1", cpu_gnt);
        end
        step();
        idle();
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h33}) begin
            n_fail++; $display("FAIL raw_data got=%b/%h want=1/33", cpu_rvalid, cpu_rdata);
        end
    endtask

    task automatic test_lock_max();
        logic [8:0] exp_lk, exp_cpu;
        exp_lk  = 9'b1_0011_1100;
        exp_cpu = 9'b0_0100_0001;
        do_reset();
        cpu_req = 1; cpu_addr = 8'h01;
        host_req = 1; host_addr = 8'h02; host_lock = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            n_cmp++;
            if ({locked, cpu_gnt, host_gnt} !== {exp_lk[i], exp_cpu[i], ~exp_cpu[i]}) begin
                n_fail++; $display("FAIL lock_max cyc=%0d got=%b want=%b", i, {locked, cpu_gnt, host_gnt},
                                   {exp_lk[i], exp_cpu[i], ~exp_cpu[i]});
            end
            step();
        end
        do_reset();
    endtask

    task automatic test_lock_release();
        logic [4:0] exp_lk, exp_cpu;
        exp_lk  = 5'b01110;
        exp_cpu = 5'b10000;
        do_reset();
        host_req = 1; host_addr = 8'h03;
        for (int i = 0; i < 5; i++) begin
            cpu_req   = (i >= 1);
            host_lock = (i < 3);
            @(negedge clock);
            n_cmp++;
            if ({locked, cpu_gnt, host_gnt} !== {exp_lk[i], exp_cpu[i], ~exp_cpu[i]}) begin
                n_fail++; $display("FAIL lock_release cyc=%0d got=%b want=%b", i, {locked, cpu_gnt, host_gnt},
                                   {exp_lk[i], exp_cpu[i], ~exp_cpu[i]});
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        host_req = 1; host_lock = 1; host_addr = 8'h10;
        step();
        step();
        reset = 1;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, host_gnt, ram_we} !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset_gnt got=%b want=000", {cpu_gnt, host_gnt, ram_we});
        end
        step();
        n_cmp++;
        if ({host_rvalid, locked, host_rdata} !== {2'b00, 8'h00}) begin
            n_fail++; $display("FAIL mid_reset_state got=%b/%h want=00/00", {host_rvalid, locked}, host_rdata);
        end
        reset = 0;
        cpu_req = 1; cpu_addr = 8'h01;
        @(negedge clock);
        n_cmp++;
        if ({locked, cpu_gnt, host_gnt} !== 3'b010) begin
            n_fail++; $display("FAIL mid_reset_contend got=%b want=010", {locked, cpu_gnt, host_gnt});
        end
        step();
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'hFF;
        @(negedge clock);
        n_cmp++;
        if ({cpu_gnt, ram_addr} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL b2b_gnt0 got=%b/%h want=1/ff", cpu_gnt, ram_addr);
        end
        step();
        cpu_addr = 8'h00;
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hC3}) begin
            n_fail++; $display("FAIL b2b_data0 got=%b/%h want=1/c3", cpu_rvalid, cpu_rdata);
        end
        step();
        cpu_req = 0;
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h3C}) begin
            n_fail++; $display("FAIL b2b_data1 got=%b/%h want=1/3c", cpu_rvalid, cpu_rdata);
        end
        step();
        n_cmp++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got=%b want=0", cpu_rvalid);
        end
    endtask

    initial begin
        reset = 1; pre_we = 0; pre_addr = 0; pre_wdata = 0;
        idle();
        preload(8'h10, 8'h5A);
        preload(8'h01, 8'h11);
        preload(8'h02, 8'h22);
        preload(8'h03, 8'h33);
        preload(8'hFF, 8'hC3);
        preload(8'h00, 8'h3C);
        test_reset();
        test_cpu_read();
        test_alternate();
        test_write_then_read();
        test_lock_max();
        test_lock_release();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data RAM between two requesters: the CPU core (load/store/ALU operand path) and a host/debug loader port.
- One RAM access per cycle.
- Round-robin arbitration, plus a bounded host lock for burst loads.
- Sits between the CPU's RAM address/data lines and the RAM instance, and returns registered read data to each requester.

Parameters:
- ADDR_BITS, 8, RAM address width.
- DATA_BITS, 8, RAM data width.
- MAX_LOCK, 16, maximum consecutive cycles the host may hold a lock; range 1..255.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- cpu_req  input  1  CPU access request; held stable until cpu_gnt.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_BITS  CPU access address.
- cpu_wdata  input  DATA_BITS  CPU write data.
- cpu_gnt  output  1  combinational accept; the access executes this cycle.
- cpu_rvalid  output  1  registered; pulses 1 cycle after a granted CPU read.
- cpu_rdata  output  DATA_BITS  registered read data; valid while cpu_rvalid is high, held otherwise.
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as the cpu_* ports, for the host.
- host_lock  input  1  host requests exclusive ownership.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_BITS  RAM address.
- ram_wdata  output  DATA_BITS  RAM write data.
- ram_rdata  input  DATA_BITS  RAM combinational read data for ram_addr.
- locked  output  1  registered; 1 while in the LOCKED state.

Behaviour:
- Clock is `clock`; reset is `reset`, synchronous, active-high.
- Reset values:
  - state = RR, last_grant = HOST (so the CPU wins the first contention), lock_cnt = 0.
  - cpu_rvalid = host_rvalid = 0; cpu_rdata = host_rdata = 0; locked = 0.
  - While reset is high, cpu_gnt, host_gnt and ram_we are forced to 0.
- Grant and mux:
  - At most one gnt per cycle.
  - The winner's addr/wdata drive ram_addr/ram_wdata.
  - ram_we = winner_we & gnt.
  - With no grant: ram_we = 0 and ram_addr = cpu_addr.
- Writes commit at the rising edge ending the grant cycle.
- Reads:
  - ram_rdata is sampled at the end of the grant cycle into the winner's rdata.
  - The winner's rvalid = 1 for exactly the next cycle.
  - Read latency is 1 cycle from gnt.
  - Back-to-back granted reads produce back-to-back rvalid pulses.
- A requester may change addr/we/wdata or drop req in the cycle after gnt. A req held high is treated as a new request.
- State RR:
  - One requester → it wins.
  - Both → the one not equal to last_grant wins.
  - last_grant updates on every grant.
  - A host grant with host_lock = 1 moves the state to LOCKED with lock_cnt = 1.
- State LOCKED:
  - Only the host may be granted; cpu_req waits (cpu_gnt = 0).
  - lock_cnt increments every cycle, granted or not.
  - Exit to RR when host_lock = 0, or when lock_cnt == MAX_LOCK. lock_cnt resets to 0 on exit.
  - On exit by MAX_LOCK, last_grant is set to HOST, so a pending CPU request wins the first RR cycle.
  - host_lock is ignored for entry until the host is granted again in RR.
- CPU priority is not configurable. Worst-case CPU wait is MAX_LOCK + 1 cycles.
- Simultaneous events:
  - Lock release and CPU request in the same cycle → the CPU is not granted that cycle; it is granted next cycle in RR.
  - Host write and CPU read of the same address in consecutive cycles → the read returns the new value.
- Reset mid-LOCKED or mid-read: state returns to RR, pending rvalid is cleared, and no data is delivered.
- Addresses wrap naturally at 2^ADDR_BITS. There is no range checking.

Test Plan:
- Only cpu_req: read addr 0x10 with RAM[0x10] = 0x5A → cpu_gnt the same cycle; cpu_rvalid = 1 and cpu_rdata = 0x5A next cycle; host_rvalid stays 0.
- cpu_req and host_req held for 6 cycles after reset → grants alternate CPU, HOST, CPU, HOST, CPU, HOST; never both gnt high.
- Host write 0x33 to 0x20, then CPU read 0x20 the next cycle → cpu_rdata = 0x33.
- Host lock with MAX_LOCK = 4, cpu_req high throughout:
  - locked = 1 for 4 cycles; cpu_gnt = 0 during them.
  - Then cpu_gnt = 1 in the first RR cycle, host_gnt = 0 that cycle.
- host_lock dropped after 2 lock cycles → locked falls; the CPU is granted on the next cycle.
- Reset asserted in the cycle after a granted host read, during LOCKED → host_rvalid = 0, locked = 0, and the first contention after reset goes to the CPU.
